// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite single-port SRAM slave. Accepts NONSEQ/SEQ transfers, inserts
//   WAIT_STATES wait cycles per OKAY data phase, writes bytes, halfwords or
//   words through lane strobes, returns the full memory word on reads, and
//   answers illegal accesses with the two-cycle ERROR response.
//
// Ports
//   hclk, hresetn          bus clock, async active-low reset
//   hsel_i, htrans_i       select / transfer type (htrans_i[1] starts a transfer)
//   haddr_i, hwrite_i      address-phase byte address and direction
//   hsize_i                0 byte, 1 halfword, 2 word, >2 illegal
//   hburst_i, hprot_i,
//   hmastlock_i            accepted and ignored
//   hwdata_i               write data, lane-aligned, sampled on the DATA edge
//   hready_i               bus ready; address phases only taken when high
//   hreadyout_o            data phase complete
//   hrdata_o               full memory word in DATA of a read, else zero
//   hresp_o                2'b00 OKAY, 2'b01 ERROR
//
// state | meaning
// IDLE  | no data phase in progress, ready, OKAY
// WAIT  | OKAY data phase stalled, cnt counts remaining wait cycles
// DATA  | OKAY data phase completing; a write commits on this edge
// ERR1  | first ERROR cycle, not ready
// ERR2  | second ERROR cycle, ready
module ahb_sram_slave #(
  parameter int unsigned                AHB_ADDR_WIDTH  = 32,
  parameter int unsigned                MEM_DEPTH_WORDS = 1024,
  parameter logic [AHB_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int unsigned                WAIT_STATES     = 0
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic                      hmastlock_i,
  input  logic [31:0]               hwdata_i,
  input  logic                      hready_i,
  output logic                      hreadyout_o,
  output logic [31:0]               hrdata_o,
  output logic [1:0]                hresp_o
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam logic [AHB_ADDR_WIDTH:0] MEM_BYTES = (AHB_ADDR_WIDTH+1)'(MEM_DEPTH_WORDS * 4);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                    state;
  state_t                    acc_state;
  logic [3:0]                cnt;
  logic [IDX_W-1:0]          idx_q;
  logic                      wr_q;
  logic [3:0]                strb_q;

  logic [AHB_ADDR_WIDTH-1:0] off;
  logic                      acc;
  logic                      acc_err;
  logic                      take;
  logic [IDX_W-1:0]          acc_idx;
  logic [3:0]                acc_strb;

  logic                      unused_in;
  assign unused_in = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

  // Address decode for the current address phase.
  assign off     = haddr_i - BASE_ADDR;
  assign acc     = hsel_i & hready_i & htrans_i[1];
  assign acc_idx = off[IDX_W+1:2];

  always_comb begin
    acc_err = 1'b0;
    if ({1'b0, off} >= MEM_BYTES)                    acc_err = 1'b1;
    if (hsize_i > 3'd2)                              acc_err = 1'b1;
    if (hsize_i == 3'd1 && haddr_i[0])               acc_err = 1'b1;
    if (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00)    acc_err = 1'b1;
  end

  // The strobe fully encodes size and lane offset, so size is not kept.
  always_comb begin
    case (hsize_i)
      3'd0:    acc_strb = 4'b0001 << haddr_i[1:0];
      3'd1:    acc_strb = 4'b0011 << haddr_i[1:0];
      default: acc_strb = 4'b1111;
    endcase
  end

  assign acc_state = acc_err ? ST_ERR1 : ((WAIT_STATES == 0) ? ST_DATA : ST_WAIT);

  // Only IDLE, DATA and ERR2 can take a new address phase.
  assign take = acc & (state != ST_WAIT) & (state != ST_ERR1);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      strb_q      <= '0;
      hreadyout_o <= 1'b1;
      hresp_o     <= RESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= ST_DATA;
            hreadyout_o <= 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_o <= 1'b1;
        end
        default: begin
          if (acc) begin
            state       <= acc_state;
            idx_q       <= acc_idx;
            wr_q        <= hwrite_i & ~acc_err;
            strb_q      <= acc_strb;
            hreadyout_o <= (acc_state == ST_DATA);
            hresp_o     <= acc_err ? RESP_ERROR : RESP_OKAY;
            if (acc_state == ST_WAIT) cnt <= 4'(WAIT_STATES);
          end else begin
            state       <= ST_IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  logic [31:0] mem [MEM_DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] fwd_word;
  logic        commit;

  assign commit = (state == ST_DATA) & wr_q;

  // Old word with the strobed lanes replaced; used both for the commit and
  // to forward into a read of the same word accepted on the commit edge.
  always_comb begin
    fwd_word = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (strb_q[i]) fwd_word[8*i +: 8] = hwdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    if (commit) mem[idx_q] <= fwd_word;
    if (take) begin
      rdata_q <= (commit && acc_idx == idx_q) ? fwd_word : mem[acc_idx];
    end else if (state == ST_WAIT && cnt == 4'd1) begin
      rdata_q <= mem[idx_q];
    end
  end

  assign hrdata_o = (state == ST_DATA && !wr_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam int          DEPTH0 = 1024;
  localparam int          WS0    = 0;
  localparam logic [31:0] BASE1  = 32'h2000_0000;
  localparam int          DEPTH1 = 64;
  localparam int          WS1    = 3;

  typedef struct {
    bit          idle;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn [2];
  logic        hsel    [2];
  logic        hwrite  [2];
  logic [31:0] haddr   [2];
  logic [31:0] hwdata  [2];
  logic [1:0]  htrans  [2];
  logic [2:0]  hsize   [2];

  logic        rdyo0, rdyo1;
  logic [31:0] rdat0, rdat1;
  logic [1:0]  resp0, resp1;

  ahb_sram_slave #(
    .AHB_ADDR_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)
  ) u_dut0 (
    .hclk(hclk), .hresetn(hresetn[0]), .hsel_i(hsel[0]), .haddr_i(haddr[0]),
    .htrans_i(htrans[0]), .hwrite_i(hwrite[0]), .hsize_i(hsize[0]),
    .hburst_i(3'b000), .hprot_i(4'b0011), .hmastlock_i(1'b0),
    .hwdata_i(hwdata[0]), .hready_i(rdyo0),
    .hreadyout_o(rdyo0), .hrdata_o(rdat0), .hresp_o(resp0)
  );

  ahb_sram_slave #(
    .AHB_ADDR_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)
  ) u_dut1 (
    .hclk(hclk), .hresetn(hresetn[1]), .hsel_i(hsel[1]), .haddr_i(haddr[1]),
    .htrans_i(htrans[1]), .hwrite_i(hwrite[1]), .hsize_i(hsize[1]),
    .hburst_i(3'b001), .hprot_i(4'b0001), .hmastlock_i(1'b0),
    .hwdata_i(hwdata[1]), .hready_i(rdyo1),
    .hreadyout_o(rdyo1), .hrdata_o(rdat1), .hresp_o(resp1)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic logic rdy_of(int d);
    return (d == 0) ? rdyo0 : rdyo1;
  endfunction
  function automatic logic [31:0] rdata_of(int d);
    return (d == 0) ? rdat0 : rdat1;
  endfunction
  function automatic logic [1:0] resp_of(int d);
    return (d == 0) ? resp0 : resp1;
  endfunction
  function automatic logic [31:0] base_of(int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction
  function automatic int depth_of(int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction
  function automatic int ws_of(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Scoreboard queues, one per slave.
  exp_t q0[$];
  exp_t q1[$];

  function automatic void push_exp(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction
  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t pop_exp(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference model: byte-addressed memory, natural-alignment rule.
  logic [7:0] mdl [2][4096];

  function automatic bit err_of(int d, logic [31:0] addr, logic [2:0] size);
    logic [31:0] off;
    off = addr - base_of(d);
    if (off >= 32'(depth_of(d) * 4)) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if ((addr & ((32'd1 << size) - 32'd1)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_issue(input int d, input req_t r);
    exp_t        e;
    logic [31:0] off;
    int          a;
    off     = r.addr - base_of(d);
    e.err   = err_of(d, r.addr, r.size);
    e.waits = e.err ? 1 : ws_of(d);
    e.rdata = 32'h0;
    if (!e.err) begin
      a = int'(off);
      if (r.write) begin
        for (int k = 0; k < (1 << r.size); k++)
          mdl[d][a+k] = r.wdata[8*((a+k)%4) +: 8];
      end else begin
        for (int k = 0; k < 4; k++)
          e.rdata[8*k +: 8] = mdl[d][(a & ~3) + k];
      end
    end
    push_exp(d, e);
  endtask

  req_t req_q[$];

  function automatic void add(bit w, logic [31:0] addr, logic [2:0] sz, logic [31:0] wd);
    req_t r;
    r.idle = 1'b0; r.write = w; r.addr = addr; r.size = sz; r.wdata = wd;
    req_q.push_back(r);
  endfunction

  function automatic req_t rand_req(int d);
    req_t        r;
    int unsigned win, sz, off;
    win     = (d == 0) ? 128 : DEPTH1 * 4;
    r.idle  = ($urandom_range(0, 5) == 0);
    r.write = 1'($urandom_range(0, 1));
    sz      = ($urandom_range(0, 15) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
    off     = $urandom_range(0, win - 1);
    if (sz <= 2 && $urandom_range(0, 9) != 0) off = (off >> sz) << sz;
    r.addr  = base_of(d) + off;
    case ($urandom_range(0, 24))
      0:       r.addr = base_of(d) + 32'(depth_of(d) * 4) + (off & 32'hFC);
      1:       r.addr = base_of(d) - 32'd4;
      default: ;
    endcase
    r.size  = 3'(sz);
    r.wdata = $urandom;
    return r;
  endfunction

  // Pipelined AHB master: address phase of the next request overlaps the
  // data phase of the current one; both advance only when ready is high.
  task automatic run(input int d);
    req_t a, dp;
    bit   a_v, dp_v;
    logic rdy;
    int   guard;
    a_v = 0; dp_v = 0; guard = 0;
    while ((req_q.size() > 0 || a_v || dp_v) && guard < 5000) begin
      if (!a_v && req_q.size() > 0) begin
        a   = req_q.pop_front();
        a_v = 1;
      end
      if (a_v && !a.idle) begin
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        hwrite[d] = a.write;
        haddr[d]  = a.addr;
        hsize[d]  = a.size;
      end else begin
        hsel[d]   = 1'($urandom_range(0, 1));
        htrans[d] = 2'($urandom_range(0, 1));
      end
      hwdata[d] = (dp_v && dp.write) ? dp.wdata : $urandom;
      rdy = rdy_of(d);
      @(posedge hclk); #1;
      guard++;
      if (rdy) begin
        dp_v = 0;
        if (a_v) begin
          if (!a.idle) begin
            dp   = a;
            dp_v = 1;
            model_issue(d, a);
          end
          a_v = 0;
        end
      end
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL driver_timeout dut%0d: stuck waiting for ready", d);
      req_q.delete();
    end
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
  endtask

  // Bus monitors: track data phases from the bus itself and compare each
  // completion against the head of the scoreboard queue.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    bit in_data  = 1'b0;
    int nlow     = 0;
    int nlow_err = 0;
    always @(negedge hclk) begin
      exp_t        e;
      logic        r;
      logic [1:0]  rs;
      logic [31:0] rd;
      r  = rdy_of(g);
      rs = resp_of(g);
      rd = rdata_of(g);
      if (!hresetn[g]) begin
        in_data  = 1'b0;
        nlow     = 0;
        nlow_err = 0;
      end else begin
        if (in_data) begin
          if (!r) begin
            nlow++;
            if (rs == 2'b01) nlow_err++;
          end else begin
            if (qsize(g) == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_completion: got resp %b expected none", g, rs);
            end else begin
              e = pop_exp(g);
              chk($sformatf("dut%0d wait_cycles", g), 32'(nlow), 32'(e.waits));
              chk($sformatf("dut%0d resp_stall", g), 32'(nlow_err), e.err ? 32'(e.waits) : 32'd0);
              chk($sformatf("dut%0d resp", g), 32'(rs), e.err ? 32'd1 : 32'd0);
              chk($sformatf("dut%0d rdata", g), rd, e.rdata);
            end
            nlow     = 0;
            nlow_err = 0;
          end
        end
        in_data = (in_data && !r) || (hsel[g] && htrans[g][1] && r);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0;
      hsel[d]    = 1'b0;
      htrans[d]  = 2'b00;
      hwrite[d]  = 1'b0;
      haddr[d]   = 32'h0;
      hsize[d]   = 3'd0;
      hwdata[d]  = 32'h0;
    end
    repeat (2) @(posedge hclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset_ready", d), 32'(rdy_of(d)), 32'd1);
      chk($sformatf("dut%0d reset_resp", d), 32'(resp_of(d)), 32'd0);
      chk($sformatf("dut%0d reset_rdata", d), rdata_of(d), 32'h0);
    end
    hresetn[0] = 1'b1;
    hresetn[1] = 1'b1;
    @(posedge hclk); #1;

    // Zero-wait slave: initialise the test window, then directed cases.
    for (int w = 0; w < 32; w++) add(1'b1, 32'(w * 4), 3'd2, $urandom);
    add(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
    add(1'b0, 32'h10, 3'd2, 32'h0);
    add(1'b1, 32'h20, 3'd2, 32'h0);
    add(1'b1, 32'h21, 3'd0, 32'h0000_AB00);
    add(1'b1, 32'h22, 3'd1, 32'h1234_0000);
    add(1'b0, 32'h20, 3'd2, 32'h0);
    add(1'b1, 32'h40, 3'd2, 32'h5555_AAAA);
    add(1'b0, 32'h40, 3'd2, 32'h0);
    add(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF);
    add(1'b1, 32'h00, 3'd3, 32'hFFFF_FFFF);
    add(1'b1, 32'h1000, 3'd2, 32'hFFFF_FFFF);
    add(1'b1, 32'h01, 3'd1, 32'hFFFF_FFFF);
    add(1'b0, 32'h1000, 3'd2, 32'h0);
    add(1'b0, 32'h00, 3'd2, 32'h0);
    for (int i = 0; i < 300; i++) req_q.push_back(rand_req(0));
    run(0);

    // Three-wait-state slave at a non-zero base.
    for (int w = 0; w < DEPTH1; w++) add(1'b1, BASE1 + 32'(w * 4), 3'd2, $urandom);
    add(1'b0, BASE1, 3'd2, 32'h0);
    add(1'b1, BASE1 + 32'(DEPTH1 * 4), 3'd2, 32'hFFFF_FFFF);
    add(1'b1, BASE1 - 32'd4, 3'd2, 32'hFFFF_FFFF);
    add(1'b0, BASE1 + 32'(DEPTH1 * 4) - 32'd4, 3'd2, 32'h0);
    for (int i = 0; i < 150; i++) req_q.push_back(rand_req(1));
    run(1);

    // Reset during the wait phase of a write: the write must be dropped.
    @(posedge hclk); #1;
    hsel[1]   = 1'b1;
    htrans[1] = 2'b10;
    hwrite[1] = 1'b1;
    haddr[1]  = BASE1 + 32'd8;
    hsize[1]  = 3'd2;
    @(posedge hclk); #1;
    hsel[1]   = 1'b0;
    htrans[1] = 2'b00;
    hwdata[1] = 32'hCAFE_F00D;
    chk("dut1 stall_before_reset", 32'(rdyo1), 32'd0);
    @(posedge hclk); #1;
    hresetn[1] = 1'b0;
    #1;
    chk("dut1 midreset_ready", 32'(rdyo1), 32'd1);
    chk("dut1 midreset_resp", 32'(resp1), 32'd0);
    chk("dut1 midreset_rdata", rdat1, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn[1] = 1'b1;
    @(posedge hclk); #1;
    add(1'b0, BASE1 + 32'd8, 3'd2, 32'h0);
    run(1);

    repeat (4) @(posedge hclk);
    #1;
    chk("dut0 scoreboard_drained", 32'(q0.size()), 32'd0);
    chk("dut1 scoreboard_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
